// File: rtl/br_pkg.sv
// Shared types for the branch predictor: BHT counter encoding, controller
// states and the BTB entry layout.
package br_pkg;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t STRONG_NT = 2'd0;
    localparam bht_cnt_t WEAK_NT   = 2'd1;
    localparam bht_cnt_t WEAK_T    = 2'd2;
    localparam bht_cnt_t STRONG_T  = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } br_state_e;

    // Tag is held as pc >> (BTB_IDX_W+2), zero-extended to fit any legal index width.
    localparam int BTB_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

endpackage

// File: rtl/br_sat_cnt2.sv
// Next value of a 2-bit saturating branch counter.
module br_sat_cnt2
    import br_pkg::*;
(
    input  bht_cnt_t cnt_i,
    input  logic     inc_i,
    output bht_cnt_t cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != STRONG_T) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != STRONG_NT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/br_pred_ctrl.sv
// Bimodal BHT + direct-mapped BTB predictor with EX-stage redirect/flush control.
// Optional BR_PRED_STATS_EN adds resolved-control and mispredict counters.
module br_pred_ctrl
    import br_pkg::*;
#(
    parameter int BHT_IDX_W = 6,
    parameter int BTB_IDX_W = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_ctrl,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    input  logic        i_fe_stall,
`ifdef BR_PRED_STATS_EN
    output logic [31:0] o_stat_ctrl,
    output logic [31:0] o_stat_mp,
`endif
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_flush,
    output logic        o_busy
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;

    bht_cnt_t   bht_q [BHT_N];
    btb_entry_t btb_q [BTB_N];

    br_state_e   state_q;
    logic [31:0] redirect_pc_q;

    function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [31:0] pc);
        logic [31:0] sh;
        sh = pc >> (BTB_IDX_W + 2);
        return sh[BTB_TAG_W-1:0];
    endfunction

    // IF lookup reads the arrays directly, so a same-cycle EX update is not visible.
    logic [BHT_IDX_W-1:0] if_bht_idx;
    logic [BTB_IDX_W-1:0] if_btb_idx;
    btb_entry_t           if_btb;
    logic                 if_btb_hit;

    assign if_bht_idx    = i_if_pc[BHT_IDX_W+1:2];
    assign if_btb_idx    = i_if_pc[BTB_IDX_W+1:2];
    assign if_btb        = btb_q[if_btb_idx];
    assign if_btb_hit    = if_btb.valid && (if_btb.tag == tag_of(i_if_pc));
    assign o_pred_taken  = bht_q[if_bht_idx][1] & if_btb_hit;
    assign o_pred_target = o_pred_taken ? if_btb.target : i_if_pc + 32'd4;

    logic                 in_run;
    logic                 ex_live;
    logic                 mp;
    logic                 upd;
    logic [31:0]          correct_pc;
    logic [BHT_IDX_W-1:0] ex_bht_idx;
    logic [BTB_IDX_W-1:0] ex_btb_idx;
    bht_cnt_t             bht_nxt;

    assign in_run     = (state_q == RUN);
    assign ex_live    = i_ex_valid & i_ex_is_ctrl;
    assign mp         = ex_live & ((i_ex_taken != i_ex_pred_taken) |
                                   (i_ex_taken & (i_ex_target != i_ex_pred_target)));
    assign upd        = in_run & ex_live;
    assign correct_pc = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
    assign ex_bht_idx = i_ex_pc[BHT_IDX_W+1:2];
    assign ex_btb_idx = i_ex_pc[BTB_IDX_W+1:2];

    br_sat_cnt2 u_bht_upd (
        .cnt_i (bht_q[ex_bht_idx]),
        .inc_i (i_ex_taken),
        .cnt_o (bht_nxt)
    );

    // In RUN the redirect is zero-latency; in HOLD the latched PC is replayed once the front end frees up.
    assign o_flush       = in_run & mp;
    assign o_redirect    = in_run ? (mp & ~i_fe_stall) : ~i_fe_stall;
    assign o_redirect_pc = (in_run & mp) ? correct_pc : redirect_pc_q;
    assign o_busy        = ~in_run;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= RUN;
            redirect_pc_q <= 32'd0;
        end else if (state_q == RUN) begin
            if (mp && i_fe_stall) begin
                redirect_pc_q <= correct_pc;
                state_q       <= HOLD;
            end
        end else if (!i_fe_stall) begin
            state_q <= RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= WEAK_NT;
            for (int i = 0; i < BTB_N; i++) btb_q[i] <= '0;
        end else if (upd) begin
            bht_q[ex_bht_idx] <= bht_nxt;
            if (i_ex_taken) begin
                btb_q[ex_btb_idx] <= '{valid: 1'b1, tag: tag_of(i_ex_pc), target: i_ex_target};
            end
        end
    end

`ifdef BR_PRED_STATS_EN
    logic [31:0] stat_ctrl_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stat_ctrl_q <= 32'd0;
            stat_mp_q   <= 32'd0;
        end else if (in_run) begin
            if (ex_live) stat_ctrl_q <= stat_ctrl_q + 32'd1;
            if (mp)      stat_mp_q   <= stat_mp_q + 32'd1;
        end
    end

    assign o_stat_ctrl = stat_ctrl_q;
    assign o_stat_mp   = stat_mp_q;
`endif

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed bench for br_pred_ctrl: lookup, training, redirect, stall/HOLD and reset-in-HOLD.
module tb_br_pred_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_ex_valid;
    logic        i_ex_is_ctrl;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic        i_fe_stall;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_flush;
    logic        o_busy;
`ifdef BR_PRED_STATS_EN
    logic [31:0] o_stat_ctrl;
    logic [31:0] o_stat_mp;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    br_pred_ctrl dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_if_pc          (i_if_pc),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .i_ex_valid       (i_ex_valid),
        .i_ex_is_ctrl     (i_ex_is_ctrl),
        .i_ex_pc          (i_ex_pc),
        .i_ex_taken       (i_ex_taken),
        .i_ex_target      (i_ex_target),
        .i_ex_pred_taken  (i_ex_pred_taken),
        .i_ex_pred_target (i_ex_pred_target),
        .i_fe_stall       (i_fe_stall),
`ifdef BR_PRED_STATS_EN
        .o_stat_ctrl      (o_stat_ctrl),
        .o_stat_mp        (o_stat_mp),
`endif
        .o_redirect       (o_redirect),
        .o_redirect_pc    (o_redirect_pc),
        .o_flush          (o_flush),
        .o_busy           (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 3 units later.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        i_ex_valid       = 1'b1;
        i_ex_is_ctrl     = 1'b1;
        i_ex_pc          = pc;
        i_ex_taken       = tk;
        i_ex_target      = tgt;
        i_ex_pred_taken  = ptk;
        i_ex_pred_target = ptgt;
    endtask

    task automatic clr_ex();
        i_ex_valid       = 1'b0;
        i_ex_is_ctrl     = 1'b0;
        i_ex_pc          = 32'd0;
        i_ex_taken       = 1'b0;
        i_ex_target      = 32'd0;
        i_ex_pred_taken  = 1'b0;
        i_ex_pred_target = 32'd0;
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc,
                              input logic exp_tk, input logic [31:0] exp_tgt);
        i_if_pc = pc;
        #1;
        check({tag, "_taken"},  {31'd0, o_pred_taken}, {31'd0, exp_tk});
        check({tag, "_target"}, o_pred_target, exp_tgt);
    endtask

    initial begin
        i_reset    = 1'b0;
        i_if_pc    = 32'd0;
        i_fe_stall = 1'b0;
        clr_ex();
        repeat (2) next_cycle();
        settle();
        check("rst_redirect",    {31'd0, o_redirect}, 32'd0);
        check("rst_flush",       {31'd0, o_flush},    32'd0);
        check("rst_busy",        {31'd0, o_busy},     32'd0);
        check("rst_redirect_pc", o_redirect_pc,       32'd0);
        i_reset = 1'b1;

        next_cycle();
        check_pred("cold_0x100", 32'h100, 1'b0, 32'h104);

        // First taken branch 0x100 -> 0x80, predicted not-taken
        next_cycle();
        set_ex(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        i_if_pc = 32'h100;
        settle();
        check("mp1_redirect",    {31'd0, o_redirect}, 32'd1);
        check("mp1_redirect_pc", o_redirect_pc,       32'h80);
        check("mp1_flush",       {31'd0, o_flush},    32'd1);
        check("mp1_busy",        {31'd0, o_busy},     32'd0);
        check("nobypass_taken",  {31'd0, o_pred_taken}, 32'd0);

        next_cycle();
        clr_ex();
        settle();
        check_pred("trained_0x100", 32'h100, 1'b1, 32'h80);
        check("idle_redirect", {31'd0, o_redirect}, 32'd0);

        // Three correctly predicted taken resolutions: counter 2 -> 3 -> 3 -> 3
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            set_ex(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            settle();
            check("hit_redirect", {31'd0, o_redirect}, 32'd0);
            check("hit_flush",    {31'd0, o_flush},    32'd0);
        end
        next_cycle();
        clr_ex();
        settle();
        check_pred("sat_hi", 32'h100, 1'b1, 32'h80);

        // Not-taken while predicted taken: counter 3 -> 2, still taken
        next_cycle();
        set_ex(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        settle();
        check("nt1_redirect",    {31'd0, o_redirect}, 32'd1);
        check("nt1_redirect_pc", o_redirect_pc,       32'h104);
        check("nt1_flush",       {31'd0, o_flush},    32'd1);
        next_cycle();
        clr_ex();
        settle();
        check_pred("after_nt1", 32'h100, 1'b1, 32'h80);

        // Second not-taken: counter 2 -> 1, now predicts not-taken
        next_cycle();
        set_ex(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        settle();
        check("nt2_redirect_pc", o_redirect_pc, 32'h104);
        next_cycle();
        clr_ex();
        settle();
        check_pred("after_nt2", 32'h100, 1'b0, 32'h104);

        // Correct not-taken predictions; stale predicted target must not matter. 1 -> 0 -> 0
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            set_ex(32'h100, 1'b0, 32'h0, 1'b0, 32'h123);
            settle();
            check("nt_ok_redirect", {31'd0, o_redirect}, 32'd0);
            check("nt_ok_flush",    {31'd0, o_flush},    32'd0);
        end
        // One taken: 0 -> 1, still not-taken (a wrap to 3 would show as taken)
        next_cycle();
        set_ex(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        settle();
        check("t_lo_redirect_pc", o_redirect_pc, 32'h80);
        next_cycle();
        clr_ex();
        settle();
        check_pred("sat_lo", 32'h100, 1'b0, 32'h104);

        // Mispredict under a 4-cycle front-end stall
        next_cycle();
        set_ex(32'h404, 1'b1, 32'h500, 1'b0, 32'h408);
        i_fe_stall = 1'b1;
        settle();
        check("st0_flush",    {31'd0, o_flush},    32'd1);
        check("st0_redirect", {31'd0, o_redirect}, 32'd0);
        check("st0_busy",     {31'd0, o_busy},     32'd0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            set_ex(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
            settle();
            check("hold_busy",     {31'd0, o_busy},     32'd1);
            check("hold_redirect", {31'd0, o_redirect}, 32'd0);
            check("hold_flush",    {31'd0, o_flush},    32'd0);
        end
        next_cycle();
        i_fe_stall = 1'b0;
        settle();
        check("rel_redirect",    {31'd0, o_redirect}, 32'd1);
        check("rel_redirect_pc", o_redirect_pc,       32'h500);
        check("rel_flush",       {31'd0, o_flush},    32'd0);
        next_cycle();
        clr_ex();
        settle();
        check("post_busy",     {31'd0, o_busy},     32'd0);
        check("post_redirect", {31'd0, o_redirect}, 32'd0);
        check_pred("hold_no_update", 32'h100, 1'b0, 32'h104);

        // JALR at 0x200: predicted 0x300, actual 0x340
        next_cycle();
        set_ex(32'h200, 1'b1, 32'h340, 1'b1, 32'h300);
        settle();
        check("jalr_redirect",    {31'd0, o_redirect}, 32'd1);
        check("jalr_redirect_pc", o_redirect_pc,       32'h340);
        check("jalr_flush",       {31'd0, o_flush},    32'd1);
        next_cycle();
        clr_ex();
        settle();
        check_pred("jalr_btb", 32'h200, 1'b1, 32'h340);
        check_pred("alias_miss", 32'h100, 1'b0, 32'h104);

        // Reset while in HOLD
        next_cycle();
        set_ex(32'h404, 1'b1, 32'h500, 1'b0, 32'h408);
        i_fe_stall = 1'b1;
        next_cycle();
        clr_ex();
        settle();
        check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        i_fe_stall = 1'b0;
        i_reset    = 1'b0;
        #1;
        check("hrst_busy",        {31'd0, o_busy},     32'd0);
        check("hrst_redirect",    {31'd0, o_redirect}, 32'd0);
        check("hrst_flush",       {31'd0, o_flush},    32'd0);
        check("hrst_redirect_pc", o_redirect_pc,       32'd0);
        check_pred("hrst_0x100", 32'h100, 1'b0, 32'h104);
        check_pred("hrst_0x200", 32'h200, 1'b0, 32'h204);
        next_cycle();
        settle();
        i_reset = 1'b1;
        next_cycle();
        settle();
        check_pred("post_rst_0x100", 32'h100, 1'b0, 32'h104);
        check("post_rst_busy", {31'd0, o_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
